// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending scoreboard and sequential clear
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]              o_rd_pending,
  input  logic [NUM_WR-1:0]              i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   i_wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   i_wr_data,
  input  logic                           i_alloc_en,
  input  logic [ADDR_WIDTH-1:0]          i_alloc_addr,
  input  logic                           i_clear,
  output logic                           o_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]        pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

  logic [NUM_WR-1:0]       wr_ok;
  logic                    alloc_ok;
  logic [ADDR_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_v;
  logic                    rd_hit;

  // Entry 0 is read-only zero only when the array is configured RISC-V style.
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualify write and alloc requests: only honoured in IDLE, never to a hardwired x0.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = i_wr_en[j] && (state_q == S_IDLE) &&
                 !is_zero(i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    alloc_ok = i_alloc_en && (state_q == S_IDLE) && !is_zero(i_alloc_addr);
  end

  // Read ports: zero reg, then forwarding (highest write port wins), then stored value.
  always_comb begin
    o_rd_data    = '0;
    o_rd_pending = '0;
    rd_a         = '0;
    rd_v         = '0;
    rd_hit       = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_a   = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_v   = regs_q[rd_a];
      rd_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_a)) begin
          rd_v   = i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          rd_hit = 1'b1;
        end
      end
      // Reads are forced to zero while clearing and while reset is held,
      // so a write presented during reset cannot leak through forwarding.
      if (is_zero(rd_a) || (state_q == S_CLEAR) || !i_rst_n) begin
        rd_v = '0;
      end
      o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_v;
      o_rd_pending[k] = pend_q[rd_a] && !rd_hit && !is_zero(rd_a);
    end
  end

  // Scoreboard: writes retire producers, a same-cycle alloc re-arms, clear start wipes all.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) pend_d[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
      if (alloc_ok) pend_d[i_alloc_addr] = 1'b1;
      if (i_clear)  pend_d = '0;
    end
  end

  // Clear engine next state: walk every index once, then return to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Storage array: clear engine owns it in CLEAR; later write ports override earlier ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int a = 0; a < DEPTH; a++) regs_q[a] <= '0;
    end else if (state_q == S_CLEAR) begin
      regs_q[idx_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          regs_q[i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign o_busy = (state_q == S_CLEAR);

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parameterised multi-port successor to the single-cycle register file, for the pipelined/dual-issue core.
- Provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports, with priority-resolved write-first forwarding.
- Adds a per-register pending scoreboard for hazard detection and a sequential clear engine that zeroes the array one entry per cycle.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH.
- NUM_RD, 2, read ports (1..8).
- NUM_WR, 2, write ports (1..4).
- ZERO_REG, 1, 1 = entry 0 hardwired to zero (RISC-V x0); 0 = entry 0 is an ordinary register.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses slice k.
- o_rd_data  out  NUM_RD*DATA_WIDTH  packed read data.
- o_rd_pending  out  NUM_RD  port k's register has an outstanding producer.
- i_wr_en  in  NUM_WR  per-port write enable.
- i_wr_addr  in  NUM_WR*ADDR_WIDTH  packed write addresses.
- i_wr_data  in  NUM_WR*DATA_WIDTH  packed write data.
- i_alloc_en  in  1  mark a destination register pending.
- i_alloc_addr  in  ADDR_WIDTH  register to mark pending.
- i_clear  in  1  start a sequential clear (level sampled, 1-cycle pulse sufficient).
- o_busy  out  1  clear engine active.

Behaviour:

Reset:
- Asserting i_rst_n low asynchronously clears all registers to 0, all pending bits to 0, the clear index to 0, and sets the FSM to IDLE.
- While in reset: o_busy=0, o_rd_pending=0, o_rd_data=0.

Writes (IDLE only):
- On a rising edge, every port j with i_wr_en[j]=1 writes i_wr_data slice j to i_wr_addr slice j.
- When several ports target the same address in one cycle, the highest-index port wins.
- With ZERO_REG=1, writes to address 0 are dropped.

Reads (combinational):
- With ZERO_REG=1, address 0 returns 0.
- Otherwise, if any enabled write port targets the same address this cycle, the read returns that port's data (highest index wins), i.e. write-first forwarding.
- Otherwise, the read returns the stored value.
- While o_busy=1, every o_rd_data slice reads 0.

Scoreboard:
- pending[a] is set on a rising edge when i_alloc_en=1 and i_alloc_addr=a.
- pending[a] is cleared on a rising edge when any enabled write targets a.
- Alloc and write to the same address in the same cycle: pending ends up 1 (the new producer wins).
- Alloc to address 0 with ZERO_REG=1 is ignored.
- o_rd_pending[k] = pending[addr_k] AND NOT (any enabled write to addr_k this cycle), consistent with forwarding.
- With ZERO_REG=1, o_rd_pending for address 0 is always 0.
- Alloc is ignored while o_busy=1.

Clear FSM:
- States: IDLE, CLEAR.
- IDLE -> CLEAR on i_clear=1. Same edge: index <= 0 and all pending bits <= 0.
- In CLEAR: each edge writes 0 to register[index] and increments index.
- When index = depth-1, that entry is cleared and the FSM returns to IDLE.
- o_busy=1 exactly while in CLEAR, i.e. for depth cycles, starting the cycle after i_clear is sampled.
- Write ports and i_alloc_en are ignored in CLEAR.
- i_clear asserted during CLEAR is ignored; it does not restart the sequence.
- i_clear and writes in the same IDLE cycle: the writes commit on that edge, then CLEAR begins.
- Reset mid-CLEAR aborts the clear; post-reset state is the reset state.

Latency and widths:
- Read latency 0; write and alloc visible on the next edge.
- The index counter is ADDR_WIDTH bits and wraps only via the IDLE return.
- No arithmetic on data.

Test Plan:
- Reset, then read all ports at addresses 0, 5, 31 -> all 0; o_busy=0; o_rd_pending=0.
- Port0 writes x5=0x11, port1 writes x5=0x22 in the same cycle; read x5 in that cycle -> 0x22 (forwarded); next cycle stored value = 0x22.
- Write x0=0xDEAD with ZERO_REG=1 -> read x0 = 0; repeat with ZERO_REG=0 -> x0 reads 0xDEAD next cycle.
- Alloc x7 -> next cycle o_rd_pending=1 for a read of x7; write x7=0x55 -> pending drops combinationally in that cycle with data 0x55 forwarded; next cycle pending=0. Simultaneous alloc and write of x7 -> pending=1 after the edge.
- Fill x1..x31 with nonzero values, pulse i_clear:
  - o_busy high for exactly 32 cycles;
  - writes and allocs issued during CLEAR have no effect;
  - all reads are 0 during CLEAR;
  - after CLEAR all entries read 0;
  - a second i_clear mid-sequence does not extend busy.
- Assert i_rst_n low at cycle 10 of CLEAR -> o_busy falls immediately; after release all registers are 0 and the FSM is IDLE.
